fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that drives the synchronous-read instruction memory's `Read_Address` and presents each returned `Instruction` to decode with a valid/ready handshake. It owns the program counter and accounts for the memory's one-cycle registered read latency. It replays the held address under back-pressure and squashes wrong-path fetches on redirect. It sits between the branch/jump logic (redirect source) and the decode stage.

## Interface

- `DATA_WIDTH`, 32: instruction width; must match the instruction memory.
- `ADDR_WIDTH`, 4: word-address width; must match the instruction memory.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:

- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  fetch enable; when low, no new fetch is issued.
- `redirect`  in  1  control-flow redirect request.
- `redirect_pc`  in  ADDR_WIDTH  redirect target word address.
- `Read_Address`  out  ADDR_WIDTH  address to the instruction memory; combinational.
- `Instruction`  in  DATA_WIDTH  registered read data from the instruction memory.
- `inst_valid`  out  1  `inst_data`/`inst_pc` hold a valid fetched instruction.
- `inst_ready`  in  1  decode accepts the instruction this cycle.
- `inst_data`  out  DATA_WIDTH  fetched instruction; direct pass-through of `Instruction`.
- `inst_pc`  out  ADDR_WIDTH  address the instruction was fetched from.

## Operation

- State registers:
  - `pc`: next address to issue.
  - `resp_valid`: memory output this cycle is a live fetch.
  - `resp_pc`: address of that fetch.
- Combinational signals:
  - `stall = resp_valid & ~inst_ready & ~redirect`.
  - `inst_valid = resp_valid & ~redirect`.
  - `inst_pc = resp_pc`.
  - `Read_Address = stall ? resp_pc : pc`.
- Next-state priority, evaluated at each rising edge:
  1. `redirect`:
     - `pc <= redirect_pc`, `resp_valid <= 0`.
     - The fetch sampled at this edge is wrong-path and is discarded.
  2. `stall`:
     - `pc`, `resp_pc` and `resp_valid` are held.
     - Memory re-reads `resp_pc`, so `Instruction` stays stable.
  3. `run`: issue a fetch; `resp_pc <= pc`, `resp_valid <= 1`, `pc <= pc + 1`.
  4. Otherwise: `resp_valid <= 0`; `pc` held.
- Boundary behaviour:
  - PC arithmetic is modulo 2^ADDR_WIDTH: `pc` wraps from 2^ADDR_WIDTH-1 to 0 silently.
  - `redirect` together with `stall` conditions: redirect wins; the held instruction is dropped, never delivered.
  - `redirect` with `run` low: `pc` is still loaded; no fetch issues until `run` is high.
  - `run` dropping while an instruction is presented and not accepted: the instruction stays presented until accepted. Stall precedes `run`.
- Reset mid-operation: all state is cleared immediately; any in-flight instruction is lost.

## Timing

- Reset values:
  - `pc = RESET_PC`, `resp_valid = 0`, `resp_pc = 0`.
  - Hence `inst_valid = 0`, `inst_pc = 0`, `Read_Address = RESET_PC`.
  - `inst_data` is undefined until the first valid fetch.
- Latency: an address issued at edge N appears with `inst_valid = 1` in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 instruction/cycle while `run` and `inst_ready` are high.
- Redirect penalty: redirect asserted in cycle C gives `inst_valid = 0` in C and C+1. The target appears in C+2.
- Combinational paths:
  - `inst_ready`/`redirect` → `Read_Address`.
  - `redirect` → `inst_valid`.
  - `Instruction` → `inst_data`.

## Configuration

- Macro: `FETCH_PERF_EN`.
- When defined, adds two outputs:
  - `fetch_count` (32): increments on each `inst_valid & inst_ready`.
  - `stall_count` (32): increments on each cycle with `stall` = 1.
  - Both reset to 0 and wrap at 2^32.
- When undefined: both ports and counters are absent; behaviour is otherwise identical.

## Test plan

- Reset, `RESET_PC = 0`, memory word k = k, `run = 1`, `inst_ready = 1` → `inst_pc`/`inst_data` = 0,1,2,… from the first cycle after reset release; no gaps.
- Stall: drop `inst_ready` for 3 cycles while `inst_pc = 5` → `inst_pc = 5`, data = 5 held for all 3 cycles. Then 6 follows with no skip or duplicate.
- Redirect: pulse `redirect` with `redirect_pc = 12` while `inst_pc = 3` → `inst_valid = 0` for 2 cycles, then `inst_pc` = 12, 13, …; 3 and 4 never accepted.
- Wrap: `ADDR_WIDTH = 4`, start at 14 → sequence 14, 15, 0, 1.
- `run = 0` for 2 cycles mid-stream after `inst_pc = 7` → valid gap of 2 cycles, then 8 with no lost address.
- With `FETCH_PERF_EN`: 10 accepted instructions plus 3 stall cycles → `fetch_count = 10`, `stall_count = 3`. Assert `reset_n` → both 0 immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a synchronous-read instruction memory.
//
// Owns the program counter, issues word addresses to the memory and presents each
// returned instruction to decode with a valid/ready handshake. The memory has one cycle
// of registered read latency, so a fetch issued at edge N is presented in the following
// cycle. Under back-pressure the held address is re-issued so the memory output stays
// stable; on redirect the in-flight (wrong-path) fetch is squashed.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   run          in   fetch enable
//   redirect     in   control-flow redirect request
//   redirect_pc  in   redirect target word address
//   Read_Address out  instruction memory address (combinational)
//   Instruction  in   registered read data from instruction memory
//   inst_valid   out  inst_data/inst_pc hold a valid instruction
//   inst_ready   in   decode accepts the instruction this cycle
//   inst_data    out  fetched instruction (pass-through of Instruction)
//   inst_pc      out  address the instruction was fetched from
//
// Optional feature, enabled by defining FETCH_PERF_EN:
//   fetch_count  out  number of accepted instructions (wraps at 2^32)
//   stall_count  out  number of back-pressure stall cycles (wraps at 2^32)

module fetch_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] Read_Address,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ResetPc = ADDR_WIDTH'(RESET_PC);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  stall;

    // Redirect overrides back-pressure: the held instruction is wrong-path and is dropped.
    assign stall        = resp_valid_q & ~inst_ready & ~redirect;
    assign inst_valid   = resp_valid_q & ~redirect;
    assign inst_pc      = resp_pc_q;
    assign inst_data    = Instruction;
    // Re-reading resp_pc while stalled keeps the memory's registered output unchanged.
    assign Read_Address = stall ? resp_pc_q : pc_q;

    always_comb begin
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        if (redirect) begin
            pc_d         = redirect_pc;
            resp_valid_d = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (run) begin
            resp_pc_d    = pc_q;
            resp_valid_d = 1'b1;
            pc_d         = pc_q + 1'b1;  // wraps modulo 2^ADDR_WIDTH
        end else begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= ResetPc;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (inst_valid && inst_ready) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural synchronous-read
// instruction memory holding word k = k. Inputs change on the falling edge and outputs
// are sampled 1 time unit later.

module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic        redirect;
    logic [3:0]  redirect_pc;
    logic [3:0]  read_address;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [3:0]  inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int unsigned num_checks;
    int unsigned num_errors;
    int unsigned fetch_exp;
    int unsigned stall_exp;

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .RESET_PC   (0)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .Read_Address (read_address),
        .Instruction  (instruction),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory word k holds value k; one cycle registered read latency.
    always @(posedge clock) instruction <= {28'd0, read_address};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs at the falling edge, then check outputs against hand values.
    task automatic step(input string tag, input logic r, input logic rd, input logic rdy,
                        input logic [3:0] rpc, input logic ev, input logic [3:0] epc,
                        input logic [3:0] era);
        @(negedge clock);
        run         = r;
        redirect    = rd;
        inst_ready  = rdy;
        redirect_pc = rpc;
        #1;
        check({tag, ".valid"}, 32'(inst_valid), 32'(ev));
        check({tag, ".raddr"}, 32'(read_address), 32'(era));
        if (ev) begin
            check({tag, ".pc"}, 32'(inst_pc), 32'(epc));
            check({tag, ".data"}, inst_data, 32'(epc));
        end
        if (ev && rdy) fetch_exp++;
        if (ev && !rdy) stall_exp++;
    endtask

    initial begin
        num_checks  = 0;
        num_errors  = 0;
        fetch_exp   = 0;
        stall_exp   = 0;
        reset_n     = 1'b0;
        run         = 1'b0;
        redirect    = 1'b0;
        inst_ready  = 1'b1;
        redirect_pc = 4'd0;

        #3;
        check("reset.valid", 32'(inst_valid), 32'd0);
        check("reset.pc", 32'(inst_pc), 32'd0);
        check("reset.raddr", 32'(read_address), 32'd0);

        @(negedge clock);
        reset_n = 1'b1;
        run     = 1'b1;
        #1;
        check("release.valid", 32'(inst_valid), 32'd0);
        check("release.raddr", 32'(read_address), 32'd0);

        // Back-to-back stream 0..4.
        for (int k = 0; k < 5; k++) begin
            step("stream", 1, 0, 1, 4'd0, 1, 4'(k), 4'(k + 1));
        end
        // Back-pressure on 5 for three cycles, then accepted, then 6.
        step("stall0", 1, 0, 0, 4'd0, 1, 4'd5, 4'd5);
        step("stall1", 1, 0, 0, 4'd0, 1, 4'd5, 4'd5);
        step("stall2", 1, 0, 0, 4'd0, 1, 4'd5, 4'd5);
        step("unstall", 1, 0, 1, 4'd0, 1, 4'd5, 4'd6);
        step("post_stall", 1, 0, 1, 4'd0, 1, 4'd6, 4'd7);
        // run low for two cycles after 7: two-cycle gap, then 8.
        step("run_off0", 0, 0, 1, 4'd0, 1, 4'd7, 4'd8);
        step("run_off1", 0, 0, 1, 4'd0, 0, 4'd0, 4'd8);
        step("run_on", 1, 0, 1, 4'd0, 0, 4'd0, 4'd8);
        step("resume8", 1, 0, 1, 4'd0, 1, 4'd8, 4'd9);
        step("resume9", 1, 0, 1, 4'd0, 1, 4'd9, 4'd10);
        // Redirect to 14 while 10 is presented; then wrap 14, 15, 0, 1, 2.
        step("redir14", 1, 1, 1, 4'd14, 0, 4'd0, 4'd11);
        step("redir14_bubble", 1, 0, 1, 4'd0, 0, 4'd0, 4'd14);
        step("wrap14", 1, 0, 1, 4'd0, 1, 4'd14, 4'd15);
        step("wrap15", 1, 0, 1, 4'd0, 1, 4'd15, 4'd0);
        step("wrap0", 1, 0, 1, 4'd0, 1, 4'd0, 4'd1);
        step("wrap1", 1, 0, 1, 4'd0, 1, 4'd1, 4'd2);
        step("seq2", 1, 0, 1, 4'd0, 1, 4'd2, 4'd3);
        // Redirect to 12 while 3 is presented and decode is not ready: 3 is dropped.
        step("redir12", 1, 1, 0, 4'd12, 0, 4'd0, 4'd4);
        step("redir12_bubble", 1, 0, 0, 4'd0, 0, 4'd0, 4'd12);
        step("tgt12", 1, 0, 1, 4'd0, 1, 4'd12, 4'd13);
        // Redirect with run low: pc loads, nothing issues until run returns.
        step("redir_norun", 0, 1, 1, 4'd2, 0, 4'd0, 4'd14);
        step("idle_norun", 0, 0, 1, 4'd0, 0, 4'd0, 4'd2);
        step("run_again", 1, 0, 1, 4'd0, 0, 4'd0, 4'd2);
        step("tgt2", 1, 0, 1, 4'd0, 1, 4'd2, 4'd3);

        // Reset mid-stream clears state immediately.
        @(negedge clock);
`ifdef FETCH_PERF_EN
        check("perf.fetch", fetch_count, 32'(fetch_exp));
        check("perf.stall", stall_count, 32'(stall_exp));
`endif
        reset_n = 1'b0;
        #1;
        check("midreset.valid", 32'(inst_valid), 32'd0);
        check("midreset.pc", 32'(inst_pc), 32'd0);
        check("midreset.raddr", 32'(read_address), 32'd0);
`ifdef FETCH_PERF_EN
        check("midreset.fetch", fetch_count, 32'd0);
        check("midreset.stall", stall_count, 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        step("restart0", 1, 0, 1, 4'd0, 1, 4'd0, 4'd1);
        step("restart1", 1, 0, 1, 4'd0, 1, 4'd1, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
